cv32e41s_pmr_mpu_gate: RTL and testbench

//  Downstream consumer of the PMP/PMR checker on one OBI-style port (instr or data).
//  - Drives the PMP check inputs for each core request.
//  - Forwards permitted requests to the bus using the PMR-relocated 34-bit address.
//  - Swallows faulting requests and returns a synthetic error response after outstanding bus traffic drains.

---
 rtl/cv32e41s_pmr_mpu_gate.sv | 129 ++++++++++++
 tb/tb_cv32e41s_pmr_mpu_gate.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e41s_pmr_mpu_gate.sv
// PMP/PMR gate for one OBI-style port: forwards permitted requests with the relocated address,
// answers faulting ones with a synthetic error once the bus drains. Option: CV32E41S_MPU_FAULT_LOG_EN.
module cv32e41s_pmr_mpu_gate #(
  parameter int IS_INSTR_PORT   = 0,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req_i,
  output logic        core_gnt_o,
  input  logic [33:0] core_addr_i,
  input  logic        core_we_i,
  input  logic        core_debug_region_i,
  output logic        core_rvalid_o,
  output logic        core_err_o,
  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  output logic [33:0] bus_addr_o,
  output logic        bus_we_o,
  input  logic        bus_rvalid_i,
  input  logic        bus_err_i,
  output logic [33:0] pmp_req_addr_o,
  output logic [1:0]  pmp_req_type_o,
  output logic        pmp_req_debug_region_o,
  input  logic [33:0] pmr_reloc_addr_i,
  input  logic        pmp_req_err_i,
  input  logic        fault_clr_i,
  output logic        fault_valid_o,
  output logic [33:0] fault_addr_o
);

  localparam int            CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  localparam logic [1:0] PMP_ACC_EXEC  = 2'b00;
  localparam logic [1:0] PMP_ACC_WRITE = 2'b01;
  localparam logic [1:0] PMP_ACC_READ  = 2'b10;

  typedef enum logic [1:0] {IDLE, DRAIN, ERR_RESP} state_e;

  state_e        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          fault_req;
  logic          permit_req;
  logic          bus_fire;
  logic          rsp_dec;

  assign pmp_req_addr_o         = core_addr_i;
  assign pmp_req_debug_region_o = core_debug_region_i;
  assign pmp_req_type_o = (IS_INSTR_PORT != 0) ? PMP_ACC_EXEC :
                          (core_we_i ? PMP_ACC_WRITE : PMP_ACC_READ);

  // Only IDLE looks at the core; faults are accepted even when the bus side is full.
  assign fault_req  = (state_reg == IDLE) && core_req_i && pmp_req_err_i;
  assign permit_req = (state_reg == IDLE) && core_req_i && !pmp_req_err_i && (cnt_reg < MAX_CNT);

  assign bus_fire = bus_req_o && bus_gnt_i;
  assign rsp_dec  = bus_rvalid_i && (cnt_reg != '0);

  always_comb begin
    cnt_next = cnt_reg;
    case ({bus_fire, rsp_dec})
      2'b10:   cnt_next = cnt_reg + CW'(1);
      2'b01:   cnt_next = cnt_reg - CW'(1);
      default: cnt_next = cnt_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // A synthetic error may only go out once every forwarded transaction has been answered.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (fault_req) state_next = (cnt_next == '0) ? ERR_RESP : DRAIN;
      DRAIN:    if (cnt_next == '0) state_next = ERR_RESP;
      ERR_RESP: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    bus_req_o     = permit_req;
    bus_addr_o    = permit_req ? pmr_reloc_addr_i : '0;
    bus_we_o      = permit_req && core_we_i && (IS_INSTR_PORT == 0);
    core_gnt_o    = fault_req || (permit_req && bus_gnt_i);
    core_rvalid_o = (state_reg == ERR_RESP) || bus_rvalid_i;
    core_err_o    = (state_reg == ERR_RESP) || (bus_rvalid_i && bus_err_i);
  end

`ifdef CV32E41S_MPU_FAULT_LOG_EN
  logic        fault_valid_reg;
  logic [33:0] fault_addr_reg;

  // Clear takes priority over a capture in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_valid_reg <= 1'b0;
      fault_addr_reg  <= '0;
    end else if (fault_clr_i) begin
      fault_valid_reg <= 1'b0;
      fault_addr_reg  <= '0;
    end else if (fault_req && !fault_valid_reg) begin
      fault_valid_reg <= 1'b1;
      fault_addr_reg  <= core_addr_i;
    end
  end

  assign fault_valid_o = fault_valid_reg;
  assign fault_addr_o  = fault_addr_reg;
`else
  logic unused_fault_clr;
  assign unused_fault_clr = fault_clr_i;
  assign fault_valid_o    = 1'b0;
  assign fault_addr_o     = '0;
`endif

  rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (rst)
    bus_rvalid_i |-> (cnt_reg != '0));

endmodule

// File: tb/tb_cv32e41s_pmr_mpu_gate.sv
// Scoreboard bench for cv32e41s_pmr_mpu_gate: stimulus pushes expected bus addresses and
// responses, a negedge monitor pops and compares them; directed checks cover same-cycle outputs.
module tb_cv32e41s_pmr_mpu_gate;

`ifdef CV32E41S_MPU_FAULT_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_req_i, core_we_i, core_debug_region_i;
  logic [33:0] core_addr_i, pmr_reloc_addr_i;
  logic        bus_gnt_i, bus_rvalid_i, bus_err_i, pmp_req_err_i, fault_clr_i;
  logic        core_gnt_o, core_rvalid_o, core_err_o, bus_req_o, bus_we_o;
  logic [33:0] bus_addr_o, pmp_req_addr_o, fault_addr_o;
  logic [1:0]  pmp_req_type_o;
  logic        pmp_req_debug_region_o, fault_valid_o;

  int compared   = 0;
  int mismatched = 0;
  logic        rsp_q[$];
  logic [33:0] bus_q[$];

  always #5 clk = ~clk;

  cv32e41s_pmr_mpu_gate #(.IS_INSTR_PORT(0), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst(rst),
    .core_req_i(core_req_i), .core_gnt_o(core_gnt_o), .core_addr_i(core_addr_i),
    .core_we_i(core_we_i), .core_debug_region_i(core_debug_region_i),
    .core_rvalid_o(core_rvalid_o), .core_err_o(core_err_o),
    .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i), .bus_addr_o(bus_addr_o), .bus_we_o(bus_we_o),
    .bus_rvalid_i(bus_rvalid_i), .bus_err_i(bus_err_i),
    .pmp_req_addr_o(pmp_req_addr_o), .pmp_req_type_o(pmp_req_type_o),
    .pmp_req_debug_region_o(pmp_req_debug_region_o),
    .pmr_reloc_addr_i(pmr_reloc_addr_i), .pmp_req_err_i(pmp_req_err_i),
    .fault_clr_i(fault_clr_i), .fault_valid_o(fault_valid_o), .fault_addr_o(fault_addr_o)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  task automatic chk34(input string name, input logic [33:0] act, input logic [33:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every bus handshake and every core response must match the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_req_o && bus_gnt_i) begin
        compared++;
        if (bus_q.size() == 0) begin
          mismatched++;
          $display("FAIL bus_req_unexpected: got request to 0x%0h, expected none", bus_addr_o);
        end else begin
          logic [33:0] ea;
          ea = bus_q.pop_front();
          compared--;
          chk34("bus_addr", bus_addr_o, ea);
          $display("txn bus addr=0x%0h", bus_addr_o);
        end
      end
      if (core_rvalid_o) begin
        compared++;
        if (rsp_q.size() == 0) begin
          mismatched++;
          $display("FAIL rsp_unexpected: got rvalid err=%0b, expected no response", core_err_o);
        end else begin
          logic ee;
          ee = rsp_q.pop_front();
          compared--;
          chk1("rsp_err", core_err_o, ee);
          $display("txn rsp err=%0b", core_err_o);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_req_i = 1'b0; core_we_i = 1'b0; core_debug_region_i = 1'b0;
    core_addr_i = '0; pmr_reloc_addr_i = '0; pmp_req_err_i = 1'b0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_err_i = 1'b0; fault_clr_i = 1'b0;
  endtask

  task automatic req(input logic [33:0] a, input logic [33:0] r, input logic we,
                     input logic err, input logic gnt);
    core_req_i = 1'b1; core_addr_i = a; pmr_reloc_addr_i = r; core_we_i = we;
    pmp_req_err_i = err; bus_gnt_i = gnt;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    idle_inputs();
    repeat (2) @(posedge clk);
    #3;
    chk1("rst_rvalid", core_rvalid_o, 1'b0);
    chk1("rst_gnt", core_gnt_o, 1'b0);
    chk1("rst_bus_req", bus_req_o, 1'b0);
    chk34("rst_bus_addr", bus_addr_o, 34'h0);
    chk1("rst_fault_valid", fault_valid_o, 1'b0);
    chk34("rst_fault_addr", fault_addr_o, 34'h0);
    chk34("rst_pmp_type", 34'(pmp_req_type_o), 34'd2);
    cyc(); rst = 1'b0;

    // Permitted request, response two cycles later
    cyc(); req(34'h1000, 34'h5000, 1'b0, 1'b0, 1'b1);
    bus_q.push_back(34'h5000); rsp_q.push_back(1'b0);
    #3;
    chk1("t1_gnt", core_gnt_o, 1'b1);
    chk1("t1_bus_req", bus_req_o, 1'b1);
    chk34("t1_bus_addr", bus_addr_o, 34'h5000);
    chk34("t1_pmp_addr", pmp_req_addr_o, 34'h1000);
    cyc(); idle_inputs();
    cyc(); bus_rvalid_i = 1'b1;
    #3 chk1("t1_rvalid", core_rvalid_o, 1'b1);
    cyc(); idle_inputs();

    // Fault while idle: synthetic error the next cycle, for one cycle only
    cyc(); req(34'h100, 34'h9100, 1'b0, 1'b1, 1'b1); rsp_q.push_back(1'b1);
    #3;
    chk1("t2_gnt", core_gnt_o, 1'b1);
    chk1("t2_bus_req", bus_req_o, 1'b0);
    cyc(); idle_inputs();
    #3;
    chk1("t2_err_rvalid", core_rvalid_o, 1'b1);
    chk1("t2_err_gnt", core_gnt_o, 1'b0);
    cyc();
    #3 chk1("t2_one_cycle", core_rvalid_o, 1'b0);

    // Second fault is not logged; clear beats a same-cycle capture
    cyc(); req(34'h200, 34'h0, 1'b1, 1'b1, 1'b1); rsp_q.push_back(1'b1);
    #3 chk34("t6_pmp_type_wr", 34'(pmp_req_type_o), 34'd1);
    cyc(); idle_inputs();
    cyc();
    #3;
    chk1("t6_fault_valid", fault_valid_o, LOG);
    chk34("t6_fault_addr", fault_addr_o, LOG ? 34'h100 : 34'h0);
    cyc(); req(34'h300, 34'h0, 1'b0, 1'b1, 1'b1); fault_clr_i = 1'b1; rsp_q.push_back(1'b1);
    cyc(); idle_inputs();
    #3 chk1("t6_clr_wins", fault_valid_o, 1'b0);
    cyc();

    // Fault behind two outstanding transactions
    cyc(); req(34'h2000, 34'h6000, 1'b1, 1'b0, 1'b1);
    bus_q.push_back(34'h6000); rsp_q.push_back(1'b0);
    #3 chk1("t3_bus_we", bus_we_o, 1'b1);
    cyc(); req(34'h2004, 34'h6004, 1'b0, 1'b0, 1'b1);
    bus_q.push_back(34'h6004); rsp_q.push_back(1'b1);
    cyc(); req(34'h2008, 34'h0, 1'b0, 1'b1, 1'b1); rsp_q.push_back(1'b1);
    #3;
    chk1("t3_fault_gnt", core_gnt_o, 1'b1);
    chk1("t3_fault_bus_req", bus_req_o, 1'b0);
    cyc(); req(34'h200c, 34'h600c, 1'b0, 1'b0, 1'b1);
    #3;
    chk1("t3_drain_gnt", core_gnt_o, 1'b0);
    chk1("t3_drain_bus_req", bus_req_o, 1'b0);
    cyc(); idle_inputs(); bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1;
    cyc(); idle_inputs(); bus_gnt_i = 1'b1;
    #3 chk1("t3_no_early_err", core_rvalid_o, 1'b0);
    cyc(); idle_inputs(); bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_err_i = 1'b1;
    cyc(); idle_inputs(); bus_gnt_i = 1'b1;
    #3 chk1("t3_err_resp", core_err_o, 1'b1);
    cyc(); idle_inputs();
    #3 chk1("t3_err_done", core_rvalid_o, 1'b0);

    // Full: permitted requests stall; grant and response together keep the count
    cyc(); req(34'h3000, 34'h7000, 1'b0, 1'b0, 1'b1); bus_q.push_back(34'h7000); rsp_q.push_back(1'b0);
    cyc(); req(34'h3004, 34'h7004, 1'b0, 1'b0, 1'b1); bus_q.push_back(34'h7004); rsp_q.push_back(1'b0);
    cyc(); req(34'h3008, 34'h7008, 1'b0, 1'b0, 1'b1);
    #3;
    chk1("t4_full_gnt", core_gnt_o, 1'b0);
    chk1("t4_full_bus_req", bus_req_o, 1'b0);
    cyc(); bus_rvalid_i = 1'b1;
    #3 chk1("t4_full_rvalid_gnt", core_gnt_o, 1'b0);
    cyc(); bus_rvalid_i = 1'b1; bus_q.push_back(34'h7008); rsp_q.push_back(1'b0);
    #3 chk1("t4_gnt_and_rvalid", core_gnt_o, 1'b1);
    cyc(); bus_rvalid_i = 1'b0; req(34'h300c, 34'h700c, 1'b0, 1'b0, 1'b1);
    bus_q.push_back(34'h700c); rsp_q.push_back(1'b0);
    #3 chk1("t4_refill_gnt", core_gnt_o, 1'b1);
    cyc(); req(34'h3010, 34'h7010, 1'b0, 1'b0, 1'b1);
    #3 chk1("t4_full_again", core_gnt_o, 1'b0);
    cyc(); idle_inputs(); bus_rvalid_i = 1'b1;
    cyc(); idle_inputs(); bus_rvalid_i = 1'b1;
    cyc(); idle_inputs();

    // Reset while draining discards the pending error and the outstanding count
    cyc(); req(34'h4000, 34'h8000, 1'b0, 1'b0, 1'b1); bus_q.push_back(34'h8000);
    cyc(); req(34'h4004, 34'h8004, 1'b0, 1'b0, 1'b1); bus_q.push_back(34'h8004);
    cyc(); req(34'h4008, 34'h0, 1'b0, 1'b1, 1'b1);
    #3 chk1("t5_fault_while_full", core_gnt_o, 1'b1);
    cyc(); idle_inputs(); rst = 1'b1;
    cyc(); rst = 1'b0;
    #3 chk1("t5_no_rvalid_0", core_rvalid_o, 1'b0);
    cyc();
    #3 chk1("t5_no_rvalid_1", core_rvalid_o, 1'b0);
    cyc(); req(34'h5000, 34'hA000, 1'b0, 1'b0, 1'b1); bus_q.push_back(34'hA000); rsp_q.push_back(1'b0);
    #3 chk1("t5_cnt0_gnt0", core_gnt_o, 1'b1);
    cyc(); req(34'h5004, 34'hA004, 1'b0, 1'b0, 1'b1); bus_q.push_back(34'hA004); rsp_q.push_back(1'b0);
    #3 chk1("t5_cnt0_gnt1", core_gnt_o, 1'b1);
    cyc(); idle_inputs(); bus_rvalid_i = 1'b1;
    cyc(); idle_inputs(); bus_rvalid_i = 1'b1;
    cyc(); idle_inputs(); req(34'h5008, 34'h0, 1'b0, 1'b1, 1'b1); rsp_q.push_back(1'b1);
    cyc(); idle_inputs();

    n = 0;
    while (rsp_q.size() != 0 && n < 20) begin
      cyc();
      n++;
    end
    chk34("rsp_q_drained", 34'(rsp_q.size()), 34'd0);
    chk34("bus_q_drained", 34'(bus_q.size()), 34'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
